// File: rtl/axi_slave_mem_if.sv
// AXI4 bus bundle between a master and the axi_slave_mem responder.
// Handshake rule for every channel: a beat transfers on a rising clk edge where VALID and READY are both 1;
// the sender keeps VALID and its payload stable until that edge, and READY may change at any time.
interface axi_slave_mem_if #(
   parameter int ID_WIDTH = 4
);
   logic [ID_WIDTH-1:0] AWID;
   logic [31:0]         AWADDR;
   logic [3:0]          AWLEN;
   logic [2:0]          AWSIZE;
   logic [1:0]          AWBURST;
   logic                AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER;
   logic                AWVALID, AWREADY;

   logic [3:0]          WID;
   logic [31:0]         WDATA;
   logic [3:0]          WSTRB;
   logic                WLAST, WUSER, WVALID, WREADY;

   logic [ID_WIDTH-1:0] BID;
   logic [1:0]          BRESP;
   logic                BUSER, BVALID, BREADY;

   logic [ID_WIDTH-1:0] ARID;
   logic [31:0]         ARADDR;
   logic [3:0]          ARLEN;
   logic [2:0]          ARSIZE;
   logic [1:0]          ARBURST;
   logic                ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER;
   logic                ARVALID, ARREADY;

   logic [ID_WIDTH-1:0] RID;
   logic [31:0]         RDATA;
   logic [3:0]          RRESP;
   logic                RLAST, RUSER, RVALID, RREADY;

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER, AWVALID,
      input  AWREADY,
      output WID, WDATA, WSTRB, WLAST, WUSER, WVALID,
      input  WREADY,
      input  BID, BRESP, BUSER, BVALID,
      output BREADY,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
      output RREADY
   );

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER, AWVALID,
      output AWREADY,
      input  WID, WDATA, WSTRB, WLAST, WUSER, WVALID,
      output WREADY,
      output BID, BRESP, BUSER, BVALID,
      input  BREADY,
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
      input  RREADY
   );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: word-addressed RAM behind independent single-outstanding write (AW/W/B) and read (AR/R) FSMs.
// FIXED/INCR/WRAP bursts of 1-16 full-width beats; bad bursts or out-of-range beats answer SLVERR.
module axi_slave_mem #(
   parameter int          ID_WIDTH  = 4,
   parameter int          MEM_DEPTH = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst,
   axi_slave_mem_if.slave bus,
   output logic [1:0]     dbg_wstate_o,
   output logic [1:0]     dbg_rstate_o
);
   localparam int          IDX_W       = $clog2(MEM_DEPTH);
   localparam logic [33:0] MEM_BYTES   = 34'(MEM_DEPTH) * 34'd4;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
   localparam logic [1:0]  R_IDLE = 2'd0, R_DATA = 2'd1;

   function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst,
                                    input logic [3:0] len, input logic [1:0] lsb);
      logic wrap_len_ok;
      wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
      return (size != 3'b010) || (burst == 2'b11) ||
             ((burst == 2'b10) && (!wrap_len_ok || (lsb != 2'b00)));
   endfunction

   function automatic logic in_range(input logic [31:0] a);
      logic [33:0] off;
      off = {2'b00, a} - {2'b00, BASE_ADDR};
      return (a >= BASE_ADDR) && (off < MEM_BYTES);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   // WRAP folds back to the boundary-aligned base once the incremented address reaches base+boundary.
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len, input logic [1:0] burst);
      logic [31:0] bytes, base, inc, res;
      bytes = ({28'd0, len} + 32'd1) << 2;
      base  = a & ~(bytes - 32'd1);
      inc   = a + 32'd4;
      case (burst)
         2'b00:   res = a;
         2'b10:   res = (inc == base + bytes) ? base : inc;
         default: res = inc;
      endcase
      return res;
   endfunction

   logic [31:0] mem_q [MEM_DEPTH];

   // Write path state
   logic [1:0]          wstate_q;
   logic                awready_q, wready_q, bvalid_q;
   logic [ID_WIDTH-1:0] wid_q, bid_q;
   logic [1:0]          bresp_q;
   logic [31:0]         waddr_q;
   logic [3:0]          wlen_q, wbeat_q;
   logic [1:0]          wburst_q;
   logic                wcfg_err_q, werr_q;

   logic w_hs, w_is_last, w_range_err, w_beat_err, mem_we;

   always_comb begin
      w_hs        = (wstate_q == W_DATA) && wready_q && bus.WVALID;
      w_is_last   = (wbeat_q == wlen_q);
      w_range_err = !in_range(waddr_q);
      w_beat_err  = wcfg_err_q || w_range_err || (bus.WLAST != w_is_last);
      mem_we      = w_hs && !wcfg_err_q && !w_range_err && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate_q   <= W_IDLE;
         awready_q  <= 1'b1;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bid_q      <= '0;
         bresp_q    <= RESP_OKAY;
         wid_q      <= '0;
         waddr_q    <= '0;
         wlen_q     <= '0;
         wbeat_q    <= '0;
         wburst_q   <= '0;
         wcfg_err_q <= 1'b0;
         werr_q     <= 1'b0;
      end else begin
         case (wstate_q)
            W_IDLE: if (bus.AWVALID && awready_q) begin
               wid_q      <= bus.AWID;
               waddr_q    <= bus.AWADDR;
               wlen_q     <= bus.AWLEN;
               wburst_q   <= bus.AWBURST;
               wcfg_err_q <= cfg_err(bus.AWSIZE, bus.AWBURST, bus.AWLEN, bus.AWADDR[1:0]);
               wbeat_q    <= '0;
               werr_q     <= 1'b0;
               awready_q  <= 1'b0;
               wready_q   <= 1'b1;
               wstate_q   <= W_DATA;
            end
            W_DATA: if (w_hs) begin
               waddr_q <= next_addr(waddr_q, wlen_q, wburst_q);
               wbeat_q <= wbeat_q + 4'd1;
               werr_q  <= werr_q || w_beat_err;
               if (w_is_last) begin
                  wready_q <= 1'b0;
                  bvalid_q <= 1'b1;
                  bid_q    <= wid_q;
                  bresp_q  <= (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                  wstate_q <= W_RESP;
               end
            end
            W_RESP: if (bus.BREADY) begin
               bvalid_q  <= 1'b0;
               awready_q <= 1'b1;
               wstate_q  <= W_IDLE;
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.WSTRB[b]) mem_q[word_idx(waddr_q)][8*b +: 8] <= bus.WDATA[8*b +: 8];
         end
      end
   end

   // Read path state; raddr_q always holds the address of the beat loaded next.
   logic [1:0]          rstate_q;
   logic                arready_q, rvalid_q, rlast_q;
   logic [ID_WIDTH-1:0] rid_q;
   logic [31:0]         rdata_q, raddr_q;
   logic [3:0]          rresp_q, rlen_q, rbeat_q;
   logic [1:0]          rburst_q;
   logic                rcfg_err_q;

   logic        r_idle, r_src_err;
   logic [31:0] r_src_addr, r_word;

   always_comb begin
      r_idle     = (rstate_q == R_IDLE);
      r_src_addr = r_idle ? bus.ARADDR : raddr_q;
      r_src_err  = (r_idle ? cfg_err(bus.ARSIZE, bus.ARBURST, bus.ARLEN, bus.ARADDR[1:0]) : rcfg_err_q)
                   || !in_range(r_src_addr);
      r_word     = mem_q[word_idx(r_src_addr)];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rstate_q   <= R_IDLE;
         arready_q  <= 1'b1;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rid_q      <= '0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         raddr_q    <= '0;
         rlen_q     <= '0;
         rbeat_q    <= '0;
         rburst_q   <= '0;
         rcfg_err_q <= 1'b0;
      end else begin
         case (rstate_q)
            R_IDLE: if (bus.ARVALID && arready_q) begin
               rid_q      <= bus.ARID;
               rlen_q     <= bus.ARLEN;
               rburst_q   <= bus.ARBURST;
               rcfg_err_q <= cfg_err(bus.ARSIZE, bus.ARBURST, bus.ARLEN, bus.ARADDR[1:0]);
               raddr_q    <= next_addr(bus.ARADDR, bus.ARLEN, bus.ARBURST);
               rbeat_q    <= '0;
               rdata_q    <= r_src_err ? 32'd0 : r_word;
               rresp_q    <= {2'b00, r_src_err ? RESP_SLVERR : RESP_OKAY};
               rlast_q    <= (bus.ARLEN == 4'd0);
               rvalid_q   <= 1'b1;
               arready_q  <= 1'b0;
               rstate_q   <= R_DATA;
            end
            R_DATA: if (bus.RREADY) begin
               if (rlast_q) begin
                  rvalid_q  <= 1'b0;
                  rlast_q   <= 1'b0;
                  arready_q <= 1'b1;
                  rstate_q  <= R_IDLE;
               end else begin
                  rbeat_q <= rbeat_q + 4'd1;
                  rlast_q <= ((rbeat_q + 4'd1) == rlen_q);
                  rdata_q <= r_src_err ? 32'd0 : r_word;
                  rresp_q <= {2'b00, r_src_err ? RESP_SLVERR : RESP_OKAY};
                  raddr_q <= next_addr(raddr_q, rlen_q, rburst_q);
               end
            end
            default: rstate_q <= R_IDLE;
         endcase
      end
   end

   assign bus.AWREADY = awready_q;
   assign bus.WREADY  = wready_q;
   assign bus.BVALID  = bvalid_q;
   assign bus.BID     = bid_q;
   assign bus.BRESP   = bresp_q;
   assign bus.BUSER   = 1'b0;
   assign bus.ARREADY = arready_q;
   assign bus.RVALID  = rvalid_q;
   assign bus.RID     = rid_q;
   assign bus.RDATA   = rdata_q;
   assign bus.RRESP   = rresp_q;
   assign bus.RLAST   = rlast_q;
   assign bus.RUSER   = 1'b0;
   assign dbg_wstate_o = wstate_q;
   assign dbg_rstate_o = rstate_q;

   logic unused_sidebands;
   assign unused_sidebands = ^{bus.AWLOCK, bus.AWCACHE, bus.AWPROT, bus.AWQOS, bus.AWREGION, bus.AWUSER,
                               bus.WID, bus.WUSER,
                               bus.ARLOCK, bus.ARCACHE, bus.ARPROT, bus.ARQOS, bus.ARREGION, bus.ARUSER};
endmodule

// File: tb/tb_axi_slave_mem.sv
// Bench for axi_slave_mem: directed scenarios plus randomized bursts checked against a word-array memory model.
module tb_axi_slave_mem;
   localparam int          DEPTH  = 1024;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam logic [31:0] TOP_W  = BASE + 32'(4 * DEPTH) - 32'd4;
   localparam int          TMO    = 200;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axi_slave_mem_if #(.ID_WIDTH(4)) bus ();
   logic [1:0] dbg_wstate, dbg_rstate;

   axi_slave_mem #(.ID_WIDTH(4), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .bus(bus), .dbg_wstate_o(dbg_wstate), .dbg_rstate_o(dbg_rstate));

   int checks = 0;
   int failures = 0;

   // Reference model and scoreboard
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] exp_q[$];
   logic [1:0]  exp_resp_q[$];

   logic [31:0] wdata_a [16];
   logic [3:0]  wstrb_a [16];
   logic        got_wready_aw, got_bvalid_last;
   logic [1:0]  got_bresp, exp_bresp;
   logic [3:0]  got_bid;
   logic [31:0] got_rdata [16];
   logic [3:0]  got_rresp [16];
   logic        got_rlast [16];
   logic [3:0]  got_rid;
   int          got_n;
   logic        got_rvalid_after, got_arready_after;

   function automatic logic [31:0] m_beat_addr(logic [31:0] start, int len, logic [1:0] burst, int i);
      longint s, bytes, base;
      s = longint'({32'd0, start});
      if (burst == 2'b00) return start;
      if (burst == 2'b10) begin
         bytes = longint'((len + 1) * 4);
         base  = (s / bytes) * bytes;
         return 32'(base + ((s - base) + 4 * i) % bytes);
      end
      return 32'(s + 4 * i);
   endfunction

   function automatic bit m_cfg_ok(logic [2:0] size, logic [1:0] burst, int len, logic [31:0] start);
      bit wl;
      wl = (len == 1) || (len == 3) || (len == 7) || (len == 15);
      return (size == 3'd2) && (burst != 2'b11) && !((burst == 2'b10) && (!wl || (start[1:0] != 2'b00)));
   endfunction

   function automatic bit m_in_range(logic [31:0] a);
      longint la, lb;
      la = longint'({32'd0, a});
      lb = longint'({32'd0, BASE});
      return (la >= lb) && (la < lb + 4 * DEPTH);
   endfunction

   task automatic wait_flag(input string name, input int which);
      int n = 0;
      while (n < TMO) begin
         if (which == 0 && bus.AWREADY === 1'b1) break;
         if (which == 1 && bus.WREADY === 1'b1) break;
         if (which == 2 && bus.BVALID === 1'b1) break;
         if (which == 3 && bus.ARREADY === 1'b1) break;
         @(posedge clk); #1; n++;
      end
      if (n >= TMO) begin
         checks++; failures++;
         $display("FAIL %s_timeout: waited %0d cycles, required handshake", name, n);
      end
   endtask

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
      bit err = 0;
      logic [31:0] a;
      int idx;
      bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
      bus.AWVALID = 1'b1;
      wait_flag("aw", 0);
      @(posedge clk); #1;
      bus.AWVALID = 1'b0;
      got_wready_aw = bus.WREADY;
      for (int i = 0; i <= int'(len); i++) begin
         bus.WVALID = 1'b1; bus.WDATA = wdata_a[i]; bus.WSTRB = wstrb_a[i]; bus.WLAST = (i == int'(len));
         wait_flag("w", 1);
         @(posedge clk); #1;
      end
      bus.WVALID = 1'b0; bus.WLAST = 1'b0;
      got_bvalid_last = bus.BVALID;
      wait_flag("b", 2);
      got_bresp = bus.BRESP; got_bid = bus.BID;
      @(posedge clk); #1;
      for (int i = 0; i <= int'(len); i++) begin
         a = m_beat_addr(addr, int'(len), burst, i);
         if (!m_cfg_ok(size, burst, int'(len), addr) || !m_in_range(a)) err = 1;
         else begin
            idx = int'((a - BASE) >> 2);
            for (int b = 0; b < 4; b++) if (wstrb_a[i][b]) ref_mem[idx][8*b +: 8] = wdata_a[i][8*b +: 8];
         end
      end
      exp_bresp = err ? 2'b10 : 2'b00;
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input bit rand_ready);
      logic [31:0] a;
      int n = 0;
      for (int i = 0; i <= int'(len); i++) begin
         a = m_beat_addr(addr, int'(len), burst, i);
         if (!m_cfg_ok(size, burst, int'(len), addr) || !m_in_range(a)) begin
            exp_q.push_back(32'd0); exp_resp_q.push_back(2'b10);
         end else begin
            exp_q.push_back(ref_mem[int'((a - BASE) >> 2)]); exp_resp_q.push_back(2'b00);
         end
      end
      bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst;
      bus.ARVALID = 1'b1;
      wait_flag("ar", 3);
      @(posedge clk); #1;
      bus.ARVALID = 1'b0;
      got_n = 0;
      while (got_n <= int'(len) && n < TMO) begin
         bus.RREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.RVALID === 1'b1 && bus.RREADY) begin
            got_rdata[got_n] = bus.RDATA; got_rresp[got_n] = bus.RRESP;
            got_rlast[got_n] = bus.RLAST; got_rid = bus.RID; got_n++;
         end
         @(posedge clk); #1; n++;
      end
      bus.RREADY = 1'b1;
      if (n >= TMO) begin
         checks++; failures++;
         $display("FAIL r_timeout: got %0d beats, required %0d", got_n, int'(len) + 1);
      end
      got_rvalid_after = bus.RVALID; got_arready_after = bus.ARREADY;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks += 11;
      if (bus.AWREADY !== 1'b1) begin failures++; $display("FAIL rst_awready: got %b exp 1", bus.AWREADY); end
      if (bus.ARREADY !== 1'b1) begin failures++; $display("FAIL rst_arready: got %b exp 1", bus.ARREADY); end
      if (bus.WREADY !== 1'b0) begin failures++; $display("FAIL rst_wready: got %b exp 0", bus.WREADY); end
      if (bus.BVALID !== 1'b0) begin failures++; $display("FAIL rst_bvalid: got %b exp 0", bus.BVALID); end
      if (bus.RVALID !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %b exp 0", bus.RVALID); end
      if (bus.RLAST !== 1'b0) begin failures++; $display("FAIL rst_rlast: got %b exp 0", bus.RLAST); end
      if (bus.BID !== 4'd0) begin failures++; $display("FAIL rst_bid: got %h exp 0", bus.BID); end
      if (bus.BRESP !== 2'd0) begin failures++; $display("FAIL rst_bresp: got %h exp 0", bus.BRESP); end
      if (bus.RID !== 4'd0) begin failures++; $display("FAIL rst_rid: got %h exp 0", bus.RID); end
      if (bus.RDATA !== 32'd0) begin failures++; $display("FAIL rst_rdata: got %h exp 0", bus.RDATA); end
      if (bus.RRESP !== 4'd0) begin failures++; $display("FAIL rst_rresp: got %h exp 0", bus.RRESP); end
   endtask

   task automatic test_incr();
      logic [31:0] e;
      for (int i = 0; i < 4; i++) begin wdata_a[i] = 32'hA0 + 32'(i); wstrb_a[i] = 4'hF; end
      axi_write(4'd5, 32'h10, 4'd3, 2'b01, 3'd2);
      checks += 4;
      if (got_wready_aw !== 1'b1) begin failures++; $display("FAIL incr_wready_lat: got %b exp 1", got_wready_aw); end
      if (got_bvalid_last !== 1'b1) begin failures++; $display("FAIL incr_bvalid_lat: got %b exp 1", got_bvalid_last); end
      if (got_bresp !== 2'b00) begin failures++; $display("FAIL incr_bresp: got %h exp 0", got_bresp); end
      if (got_bid !== 4'd5) begin failures++; $display("FAIL incr_bid: got %h exp 5", got_bid); end
      axi_read(4'd6, 32'h10, 4'd3, 2'b01, 3'd2, 1'b0);
      for (int i = 0; i < got_n; i++) begin
         e = exp_q.pop_front(); void'(exp_resp_q.pop_front());
         checks += 4;
         if (got_rdata[i] !== 32'hA0 + 32'(i) || got_rdata[i] !== e) begin failures++; $display("FAIL incr_rdata[%0d]: got %h exp %h", i, got_rdata[i], e); end
         if (got_rresp[i] !== 4'd0) begin failures++; $display("FAIL incr_rresp[%0d]: got %h exp 0", i, got_rresp[i]); end
         if (got_rlast[i] !== (i == 3)) begin failures++; $display("FAIL incr_rlast[%0d]: got %b exp %b", i, got_rlast[i], i == 3); end
         if (got_rid !== 4'd6) begin failures++; $display("FAIL incr_rid: got %h exp 6", got_rid); end
      end
      checks += 2;
      if (got_rvalid_after !== 1'b0) begin failures++; $display("FAIL incr_rvalid_end: got %b exp 0", got_rvalid_after); end
      if (got_arready_after !== 1'b1) begin failures++; $display("FAIL incr_arready_end: got %b exp 1", got_arready_after); end
   endtask

   task automatic test_wrap();
      logic [31:0] lit [4];
      logic [31:0] e;
      lit = '{32'd3, 32'd4, 32'd1, 32'd2};
      for (int i = 0; i < 4; i++) begin wdata_a[i] = 32'(i + 1); wstrb_a[i] = 4'hF; end
      axi_write(4'd1, 32'h10, 4'd3, 2'b01, 3'd2);
      axi_read(4'd2, 32'h18, 4'd3, 2'b10, 3'd2, 1'b0);
      for (int i = 0; i < got_n; i++) begin
         e = exp_q.pop_front(); void'(exp_resp_q.pop_front());
         checks += 2;
         if (got_rdata[i] !== lit[i] || got_rdata[i] !== e) begin failures++; $display("FAIL wrap_rdata[%0d]: got %h exp %h", i, got_rdata[i], lit[i]); end
         if (got_rlast[i] !== (i == 3)) begin failures++; $display("FAIL wrap_rlast[%0d]: got %b exp %b", i, got_rlast[i], i == 3); end
      end
   endtask

   task automatic test_strobe();
      wdata_a[0] = 32'h1234_5678; wstrb_a[0] = 4'hF;
      axi_write(4'd0, 32'h0, 4'd0, 2'b01, 3'd2);
      wdata_a[0] = 32'hFFFF_FFFF; wstrb_a[0] = 4'b0101;
      axi_write(4'd0, 32'h0, 4'd0, 2'b01, 3'd2);
      axi_read(4'd0, 32'h0, 4'd0, 2'b01, 3'd2, 1'b0);
      void'(exp_q.pop_front()); void'(exp_resp_q.pop_front());
      checks++;
      if (got_rdata[0] !== 32'h12FF_56FF) begin failures++; $display("FAIL strobe_rdata: got %h exp 12ff56ff", got_rdata[0]); end
   endtask

   task automatic test_stall();
      logic        pat [4];
      logic [31:0] held_d;
      logic [3:0]  held_r;
      logic        held_l;
      bit          stalled = 0;
      int          beats = 0;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      bus.ARID = 4'd3; bus.ARADDR = 32'h10; bus.ARLEN = 4'd1; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01;
      bus.ARVALID = 1'b1;
      wait_flag("stall_ar", 3);
      @(posedge clk); #1;
      bus.ARVALID = 1'b0;
      for (int c = 0; c < 8; c++) begin
         bus.RREADY = (c < 4) ? pat[c] : 1'b1;
         if (stalled) begin
            checks++;
            if (bus.RVALID !== 1'b1 || bus.RDATA !== held_d || bus.RRESP !== held_r || bus.RLAST !== held_l) begin
               failures++; $display("FAIL stall_hold c%0d: got v%b d%h r%h l%b exp v1 d%h r%h l%b",
                                    c, bus.RVALID, bus.RDATA, bus.RRESP, bus.RLAST, held_d, held_r, held_l);
            end
         end
         if (bus.RVALID === 1'b1) begin
            held_d = bus.RDATA; held_r = bus.RRESP; held_l = bus.RLAST;
            stalled = !bus.RREADY;
            if (bus.RREADY) begin
               checks += 2;
               if (bus.RDATA !== 32'(beats + 1)) begin failures++; $display("FAIL stall_rdata[%0d]: got %h exp %h", beats, bus.RDATA, beats + 1); end
               if (bus.RLAST !== (beats == 1)) begin failures++; $display("FAIL stall_rlast[%0d]: got %b exp %b", beats, bus.RLAST, beats == 1); end
               beats++;
            end
         end else stalled = 0;
         @(posedge clk); #1;
      end
      checks++;
      if (beats != 2) begin failures++; $display("FAIL stall_beats: got %0d exp 2", beats); end
   endtask

   task automatic test_boundary();
      logic [31:0] e;
      logic [1:0]  er;
      wdata_a[0] = 32'hCAFE_0001; wstrb_a[0] = 4'hF;
      axi_write(4'd7, TOP_W, 4'd0, 2'b01, 3'd2);
      axi_read(4'd7, TOP_W, 4'd1, 2'b01, 3'd2, 1'b0);
      for (int i = 0; i < got_n; i++) begin
         e = exp_q.pop_front(); er = exp_resp_q.pop_front();
         checks += 2;
         if (got_rdata[i] !== e || got_rdata[i] !== ((i == 0) ? 32'hCAFE_0001 : 32'd0)) begin failures++; $display("FAIL bnd_rdata[%0d]: got %h exp %h", i, got_rdata[i], e); end
         if (got_rresp[i] !== {2'b00, er} || er !== ((i == 0) ? 2'b00 : 2'b10)) begin failures++; $display("FAIL bnd_rresp[%0d]: got %h exp %h", i, got_rresp[i], er); end
      end
      wdata_a[0] = 32'h5A5A_0001; wdata_a[1] = 32'h5A5A_0002; wstrb_a[0] = 4'hF; wstrb_a[1] = 4'hF;
      axi_write(4'd8, TOP_W, 4'd1, 2'b01, 3'd2);
      checks++;
      if (got_bresp !== 2'b10 || exp_bresp !== 2'b10) begin failures++; $display("FAIL bnd_bresp: got %h exp 2", got_bresp); end
      axi_read(4'd8, TOP_W, 4'd0, 2'b01, 3'd2, 1'b0);
      e = exp_q.pop_front(); void'(exp_resp_q.pop_front());
      checks++;
      if (got_rdata[0] !== 32'h5A5A_0001 || e !== 32'h5A5A_0001) begin failures++; $display("FAIL bnd_written: got %h exp 5a5a0001", got_rdata[0]); end
   endtask

   task automatic test_errors();
      logic [2:0]  sz [4];
      logic [1:0]  bt [4];
      logic [3:0]  ln [4];
      logic [31:0] ad [4];
      sz = '{3'd1, 3'd2, 3'd2, 3'd2};
      bt = '{2'b01, 2'b11, 2'b10, 2'b10};
      ln = '{4'd0, 4'd1, 4'd2, 4'd3};
      ad = '{32'h10, 32'h10, 32'h10, 32'h12};
      for (int k = 0; k < 4; k++) begin
         axi_read(4'(k), ad[k], ln[k], bt[k], sz[k], 1'b0);
         checks++;
         if (got_n != int'(ln[k]) + 1) begin failures++; $display("FAIL err%0d_beats: got %0d exp %0d", k, got_n, int'(ln[k]) + 1); end
         for (int i = 0; i < got_n; i++) begin
            void'(exp_q.pop_front()); void'(exp_resp_q.pop_front());
            checks += 3;
            if (got_rresp[i] !== 4'b0010) begin failures++; $display("FAIL err%0d_rresp[%0d]: got %h exp 2", k, i, got_rresp[i]); end
            if (got_rdata[i] !== 32'd0) begin failures++; $display("FAIL err%0d_rdata[%0d]: got %h exp 0", k, i, got_rdata[i]); end
            if (got_rlast[i] !== (i == int'(ln[k]))) begin failures++; $display("FAIL err%0d_rlast[%0d]: got %b", k, i, got_rlast[i]); end
         end
      end
      wdata_a[0] = 32'hDEAD_BEEF; wstrb_a[0] = 4'hF;
      axi_write(4'd9, 32'h14, 4'd0, 2'b01, 3'd1);
      checks++;
      if (got_bresp !== 2'b10) begin failures++; $display("FAIL err_wsize_bresp: got %h exp 2", got_bresp); end
      axi_read(4'd9, 32'h14, 4'd0, 2'b01, 3'd2, 1'b0);
      void'(exp_resp_q.pop_front());
      checks++;
      if (got_rdata[0] !== exp_q.pop_front() || got_rdata[0] !== 32'd2) begin failures++; $display("FAIL err_wsize_unwritten: got %h exp 2", got_rdata[0]); end
   endtask

   task automatic test_reset_mid();
      bus.AWID = 4'd4; bus.AWADDR = 32'h40; bus.AWLEN = 4'd3; bus.AWSIZE = 3'd2; bus.AWBURST = 2'b01;
      bus.AWVALID = 1'b1;
      wait_flag("rm_aw", 0);
      @(posedge clk); #1;
      bus.AWVALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.WVALID = 1'b1; bus.WDATA = 32'h7700 + 32'(i); bus.WSTRB = 4'hF; bus.WLAST = 1'b0;
         wait_flag("rm_w", 1);
         @(posedge clk); #1;
         ref_mem[16 + i] = 32'h7700 + 32'(i);
      end
      bus.WVALID = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks += 3;
      if (bus.AWREADY !== 1'b1) begin failures++; $display("FAIL rm_awready: got %b exp 1", bus.AWREADY); end
      if (bus.WREADY !== 1'b0) begin failures++; $display("FAIL rm_wready: got %b exp 0", bus.WREADY); end
      if (bus.BVALID !== 1'b0) begin failures++; $display("FAIL rm_bvalid: got %b exp 0", bus.BVALID); end
      for (int i = 0; i < 4; i++) begin wdata_a[i] = 32'h8800 + 32'(i); wstrb_a[i] = 4'hF; end
      axi_write(4'd4, 32'h40, 4'd3, 2'b01, 3'd2);
      checks += 2;
      if (got_bresp !== 2'b00) begin failures++; $display("FAIL rm_bresp: got %h exp 0", got_bresp); end
      if (got_bid !== 4'd4) begin failures++; $display("FAIL rm_bid: got %h exp 4", got_bid); end
      axi_read(4'd4, 32'h40, 4'd3, 2'b01, 3'd2, 1'b0);
      for (int i = 0; i < got_n; i++) begin
         void'(exp_resp_q.pop_front());
         checks++;
         if (got_rdata[i] !== exp_q.pop_front()) begin failures++; $display("FAIL rm_rdata[%0d]: got %h exp %h", i, got_rdata[i], 32'h8800 + 32'(i)); end
      end
   endtask

   task automatic pick_burst(output logic [31:0] addr, output logic [3:0] len, output logic [1:0] burst);
      int lens [4] = '{1, 3, 7, 15};
      burst = 2'($urandom_range(0, 2));
      if (burst == 2'b10) len = 4'(lens[$urandom_range(0, 3)]);
      else len = 4'($urandom_range(0, 15));
      if (burst == 2'b01) addr = 32'h100 + 32'(4 * $urandom_range(0, 127 - int'(len)));
      else addr = 32'h100 + 32'(4 * $urandom_range(0, 127));
   endtask

   task automatic test_random();
      logic [31:0] a, e;
      logic [3:0]  l, id;
      logic [1:0]  bt, er;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 16; i++) begin wdata_a[i] = $urandom; wstrb_a[i] = 4'hF; end
         axi_write(4'd0, 32'h100 + 32'(64 * k), 4'd15, 2'b01, 3'd2);
      end
      for (int t = 0; t < 25; t++) begin
         pick_burst(a, l, bt);
         id = 4'($urandom_range(0, 15));
         for (int i = 0; i < 16; i++) begin wdata_a[i] = $urandom; wstrb_a[i] = 4'($urandom_range(0, 15)); end
         axi_write(id, a, l, bt, 3'd2);
         checks += 2;
         if (got_bresp !== exp_bresp) begin failures++; $display("FAIL rnd%0d_bresp: got %h exp %h", t, got_bresp, exp_bresp); end
         if (got_bid !== id) begin failures++; $display("FAIL rnd%0d_bid: got %h exp %h", t, got_bid, id); end
         pick_burst(a, l, bt);
         id = 4'($urandom_range(0, 15));
         axi_read(id, a, l, bt, 3'd2, 1'b1);
         for (int i = 0; i < got_n; i++) begin
            e = exp_q.pop_front(); er = exp_resp_q.pop_front();
            checks += 3;
            if (got_rdata[i] !== e || got_rresp[i] !== {2'b00, er}) begin failures++; $display("FAIL rnd%0d_beat[%0d]: got %h/%h exp %h/%h", t, i, got_rdata[i], got_rresp[i], e, er); end
            if (got_rlast[i] !== (i == int'(l))) begin failures++; $display("FAIL rnd%0d_rlast[%0d]: got %b", t, i, got_rlast[i]); end
            if (got_rid !== id) begin failures++; $display("FAIL rnd%0d_rid: got %h exp %h", t, got_rid, id); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      for (int i = 0; i < 8; i++) begin wdata_a[i] = $urandom; wstrb_a[i] = 4'hF; end
      fork
         axi_write(4'd10, 32'h300, 4'd7, 2'b01, 3'd2);
         axi_read(4'd11, 32'h100, 4'd15, 2'b01, 3'd2, 1'b0);
      join
      checks++;
      if (got_bresp !== 2'b00) begin failures++; $display("FAIL b2b_bresp: got %h exp 0", got_bresp); end
      for (int i = 0; i < got_n; i++) begin
         e = exp_q.pop_front(); void'(exp_resp_q.pop_front());
         checks++;
         if (got_rdata[i] !== e) begin failures++; $display("FAIL b2b_rdata[%0d]: got %h exp %h", i, got_rdata[i], e); end
      end
      axi_read(4'd12, 32'h300, 4'd7, 2'b01, 3'd2, 1'b0);
      for (int i = 0; i < got_n; i++) begin
         e = exp_q.pop_front(); void'(exp_resp_q.pop_front());
         checks++;
         if (got_rdata[i] !== e || e !== wdata_a[i]) begin failures++; $display("FAIL b2b_wr_rdata[%0d]: got %h exp %h", i, got_rdata[i], wdata_a[i]); end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
      rst = 1'b1;
      bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
      bus.AWLOCK = 0; bus.AWCACHE = 0; bus.AWPROT = 0; bus.AWQOS = 0; bus.AWREGION = 0; bus.AWUSER = 0;
      bus.AWVALID = 0;
      bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 0; bus.WUSER = 0; bus.WVALID = 0;
      bus.BREADY = 1'b1;
      bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
      bus.ARLOCK = 0; bus.ARCACHE = 0; bus.ARPROT = 0; bus.ARQOS = 0; bus.ARREGION = 0; bus.ARUSER = 0;
      bus.ARVALID = 0;
      bus.RREADY = 1'b1;
      test_reset();
      test_incr();
      test_wrap();
      test_strobe();
      test_stall();
      test_boundary();
      test_errors();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- Synthesizable AXI4 slave memory responder; the RTL DUT at the slave end of the AXI bus, driven by the master VIP driver and watched by both monitors.
- Independent write path (AW/W/B) and read path (AR/R), one outstanding transaction per path.
- Word-addressed internal RAM; FIXED/INCR/WRAP bursts, 4-bit LEN (1–16 beats), full-width transfers only.

Parameters:
- ID_WIDTH, 4, width of AWID/BID/ARID/RID
- MEM_DEPTH, 1024, RAM depth in 32-bit words
- BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- AWID AWADDR AWLEN AWSIZE AWBURST  in  ID_WIDTH/32/4/3/2  write address
- AWLOCK AWCACHE AWPROT AWQOS AWREGION AWUSER  in  1 each  ignored
- AWVALID in 1; AWREADY out 1
- WID in 4 (ignored); WDATA in 32; WSTRB in 4; WLAST in 1; WUSER in 1 (ignored); WVALID in 1; WREADY out 1
- BID out ID_WIDTH; BRESP out 2; BUSER out 1 (always 0); BVALID out 1; BREADY in 1
- ARID ARADDR ARLEN ARSIZE ARBURST  in  ID_WIDTH/32/4/3/2  read address
- ARLOCK ARCACHE ARPROT ARQOS ARREGION ARUSER  in  1 each  ignored
- ARVALID in 1; ARREADY out 1
- RID out ID_WIDTH; RDATA out 32; RRESP out 4 ([3:2] always 0); RLAST out 1; RUSER out 1 (always 0); RVALID out 1; RREADY in 1

Behaviour:
- Single clock clk, synchronous active-high reset rst. All outputs registered.
- Reset: AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST=0; BID, BRESP, RID, RDATA, RRESP=0. Both FSMs go to IDLE. RAM contents are not reset. Reset mid-burst abandons the burst immediately.
- Write FSM:
  - W_IDLE (AWREADY=1): on AWVALID&AWREADY at edge N, latch ID/ADDR/LEN/SIZE/BURST, clear beat count and error flag; go W_DATA. AWREADY=0, WREADY=1 from N+1.
  - W_DATA (WREADY=1): each WVALID&WREADY writes WDATA byte lanes enabled by WSTRB, then advances the address.
  - Final beat is beat LEN. On that beat go W_RESP: WREADY=0, BVALID=1, BID=latched ID from the next cycle.
  - W_RESP: hold BVALID/BID/BRESP stable until BREADY. Then BVALID=0, AWREADY=1, return to W_IDLE.
- Read FSM:
  - R_IDLE (ARREADY=1): on AR handshake at edge N, go R_DATA. ARREADY=0; RVALID=1 with beat 0 data from N+1.
  - R_DATA: hold RID/RDATA/RRESP/RLAST stable while RVALID&!RREADY.
  - On each accepted beat, the next beat is presented the following cycle. With RREADY held high, one beat per cycle.
  - RLAST=1 on beat LEN only. After it is accepted, RVALID=0 and ARREADY=1 next cycle.
- Address generation (per beat, step 4 bytes):
  - FIXED: address constant.
  - INCR: addr+4.
  - WRAP: boundary = (LEN+1)*4 bytes; addr wraps to the aligned base when the next address reaches base+boundary.
  - Word index = (addr-BASE_ADDR)>>2.
- Error rules: any of the following makes the response SLVERR (2'b10); otherwise OKAY (2'b00).
  - SIZE≠3'b010
  - BURST=2'b11
  - WRAP with LEN ∉ {1,3,7,15}
  - Unaligned WRAP start
  - Beat address outside [BASE_ADDR, BASE_ADDR+4*MEM_DEPTH)
- Error handling per path:
  - Writes: an erroring beat is not written; BRESP=SLVERR if any beat errored.
  - Writes: WLAST≠(beat==LEN) sets the error flag. The burst still ends on beat LEN.
  - Reads: per-beat RRESP; an erroring beat returns RDATA=0.
- Read/write collision: a RAM write at edge N is visible to read data loaded at edge N+1 or later. A read beat loaded at the same edge N returns old data.
- Write and read paths run concurrently with no mutual stalling.

Test Plan:
- Write INCR AWADDR=0x10 AWLEN=3 WDATA 0xA0..0xA3 WSTRB=F, BREADY=1:
  - WREADY rises 1 cycle after AW handshake.
  - BVALID 1 cycle after the WLAST beat, BRESP=0, BID=AWID.
  - Then read the same burst: RDATA 0xA0..0xA3, RLAST on 4th beat, RRESP=0.
- WRAP read ARADDR=0x18 ARLEN=3 after filling 0x10–0x1C with 1..4 → beats from 0x18,0x1C,0x10,0x14 = 3,4,1,2.
- WSTRB=4'b0101 write of 0xFFFFFFFF over 0x12345678 at 0x0 → read returns 0x12FF56FF.
- RREADY toggling 1,0,0,1 during a 2-beat read → RDATA/RRESP/RLAST held stable while stalled; exactly 2 beats delivered.
- ARADDR=BASE_ADDR+4*MEM_DEPTH-4, ARLEN=1 INCR → beat0 RRESP=0, beat1 RRESP=2'b10 with RDATA=0. Same pattern as a write → BRESP=2'b10 and in-range word written.
- rst asserted mid write burst (after beat 1 of 4) → next cycle AWREADY=1, WREADY=0, BVALID=0; a subsequent full write completes with BRESP=0.
